// File: rtl/pipe_pkg.sv
// Shared constants and the occupancy helper for the three-stage elastic pipeline.
package pipe_pkg;
    localparam int WIDTH_DEFAULT = 8;
    localparam int NUM_STAGES    = 3;
    localparam int COUNT_W       = $clog2(NUM_STAGES + 1);

    typedef logic [COUNT_W-1:0] occ_t;

    function automatic occ_t occupancy(input logic v1, input logic v2, input logic v3);
        return occ_t'({1'b0, v1}) + occ_t'({1'b0, v2}) + occ_t'({1'b0, v3});
    endfunction
endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit and a data word behind a shared load enable.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // The data word only captures real words, so empty slots moving through do not toggle it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_elastic_3.sv
// Three-stage elastic pipeline with bubble compression and registered outputs.
module pipe_elastic_3
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       count
);
    logic             v1, v2, v3;
    logic [WIDTH-1:0] d1, d2, d3;
    logic             adv1, adv2, adv3;
    logic             nv1, nv2, nv3;
    occ_t             count_q, count_d;

    // A stage moves whenever it is empty or the stage after it moves; this is what squeezes out bubbles.
    assign adv3 = !v3 | m_ready;
    assign adv2 = !v2 | adv3;
    assign adv1 = !v1 | adv2;
    assign s_ready = adv1;

    pipe_stage #(.WIDTH(WIDTH)) u_s1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (adv1),
        .valid_i (s_valid),
        .data_i  (s_data),
        .valid_o (v1),
        .data_o  (d1)
    );

    pipe_stage #(.WIDTH(WIDTH)) u_s2 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (adv2),
        .valid_i (v1),
        .data_i  (d1),
        .valid_o (v2),
        .data_o  (d2)
    );

    pipe_stage #(.WIDTH(WIDTH)) u_s3 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (adv3),
        .valid_i (v2),
        .data_i  (d2),
        .valid_o (v3),
        .data_o  (d3)
    );

    // Occupancy is registered from the next-state valids so it always matches the stage registers.
    always_comb begin
        nv1     = adv1 ? s_valid : v1;
        nv2     = adv2 ? v1 : v2;
        nv3     = adv3 ? v2 : v3;
        count_d = occupancy(nv1, nv2, nv3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign m_valid = v3;
    assign m_data  = d3;
    assign count   = count_q;
endmodule

// File: doc/pipe_elastic_3.md
PIPE_ELASTIC_3 -- requirements
Module: pipe_elastic_3

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 s_valid  input  1  upstream data valid.
REQ-005 s_ready  output  1  block can accept s_data this cycle.
REQ-006 s_data  input  WIDTH  upstream data.
REQ-007 m_valid  output  1  m_data valid to downstream.
REQ-008 m_ready  input  1  downstream accepts m_data this cycle.
REQ-009 m_data  output  WIDTH  downstream data.
REQ-010 count  output  2  number of occupied stages, 0..3.

Function
REQ-011 Three register stages S1->S2->S3 SHALL be used, each holding a data word and a valid bit; S3 drives m_data/m_valid directly (registered outputs).
REQ-012 Input transfer SHALL occur when s_valid & s_ready; output transfer SHALL occur when m_valid & m_ready.
REQ-013 Stage advance enables SHALL be: adv3 = !v3 | m_ready; adv2 = !v2 | adv3; adv1 = !v1 | adv2; s_ready = adv1 (combinational, no dependence on s_valid).
REQ-014 When advk is high, stage k SHALL load the content and valid bit of stage k-1 (S1 loads s_data/s_valid); when low, stage k SHALL hold.
REQ-015 Latency SHALL be exactly 3 cycles from input transfer to m_valid high with no backpressure; throughput SHALL be one word per cycle, sustained.
REQ-016 Bubbles SHALL compress: an empty stage always loads, so a word never waits behind an empty stage.
REQ-017 While m_valid & !m_ready, m_data and m_valid SHALL remain stable.
REQ-018 Full (count=3) with m_ready=0: s_ready SHALL be 0 and no data SHALL be lost or overwritten.
REQ-019 Full with m_ready=1: s_ready SHALL be 1 in the same cycle; simultaneous input and output transfers SHALL occur, count unchanged.
REQ-020 Empty (count=0): m_valid SHALL be 0 and s_ready SHALL be 1.
REQ-021 count SHALL equal v1+v2+v3, updated registered each cycle, never exceeding 3.
REQ-022 Word order SHALL be preserved; no duplication or drop under any m_ready/s_valid pattern.
REQ-023 Data stage registers SHALL load only when their valid input is 1 (reduced toggling); valid bits follow REQ-014 unconditionally.
REQ-024 All sequential logic SHALL use nonblocking assignments; result SHALL be independent of always-block evaluation order (no simulation race).

Reset
REQ-025 While rst_n=0 at a rising edge: v1..v3 SHALL clear to 0, all data registers to 0, hence m_valid=0, m_data=0, count=0.
REQ-026 s_ready SHALL be 1 in the cycle after reset; transfers presented during reset SHALL be discarded.
REQ-027 Reset asserted mid-stream SHALL flush all in-flight words; no word emerges after reset release unless newly accepted.

Structure
REQ-028 Package pipe_pkg SHALL hold WIDTH_DEFAULT=8 and NUM_STAGES=3 constants.
REQ-029 One sub-module pipe_stage (data+valid register with load enable, sync active-low reset) SHALL be instantiated three times; advance logic lives in the top.

Verification
REQ-030 Stream 0x01..0x05 back-to-back, m_ready=1 -> m_data 0x01 three cycles after first accept, then 0x02..0x05 on consecutive cycles, count steady at 3 during stream.
REQ-031 Send 0x0A,0x0B,0x0C with m_ready=0 -> count=3, s_ready=0, m_data held 0x0A; raise m_ready -> 0x0A,0x0B,0x0C out on 3 consecutive cycles.
REQ-032 Full, m_ready=1, s_valid=1 with 0x0D -> s_ready=1 same cycle, 0x0A out, count stays 3, 0x0D emerges after 0x0C.
REQ-033 Inputs 0x11,idle,idle,0x22 with m_ready toggling 0/1 each cycle -> output order 0x11,0x22, m_data stable whenever m_valid&!m_ready.
REQ-034 Load 0x31,0x32 then rst_n=0 one cycle -> next cycle m_valid=0, count=0, s_ready=1; neither word ever appears on m_data.
REQ-035 Random s_valid/m_ready 10k cycles vs scoreboard FIFO -> zero mismatches, count always equals scoreboard depth in pipeline.
